dmem_param: RTL and testbench

DMEM_PARAM -- requirements
Module: dmem_param

---
 rtl/dmem_param.sv | 105 ++++++++++
 tb/tb_dmem_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_param.sv
// Single-port word memory with a periodic refusal schedule and 1-cycle read latency.
// Optional refusal statistics counter enabled by defining DMEM_STATS_EN.
module dmem_param #(
  parameter int A_WIDTH       = 13,
  parameter int D_WIDTH       = 34,
  parameter int REFUSE_PERIOD = 8,
  parameter int REFUSE_CYCLES = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic [D_WIDTH-1:0] din_i,
  output logic [D_WIDTH-1:0] dout_o,
  output logic               valid_o,
  output logic               refused_o
`ifdef DMEM_STATS_EN
  ,
  input  logic               stats_clr_i,
  output logic [CNT_WIDTH-1:0] refused_count_o
`endif
);

  localparam int PH_W = (REFUSE_PERIOD > 2) ? $clog2(REFUSE_PERIOD) : 1;
  localparam logic [PH_W-1:0] WIN_START = PH_W'(REFUSE_PERIOD - REFUSE_CYCLES);

  if ((REFUSE_PERIOD < 2) || ((REFUSE_PERIOD & (REFUSE_PERIOD - 1)) != 0)) begin : g_bad_period
    $error("dmem_param: REFUSE_PERIOD must be a power of two and at least 2");
  end
  if ((REFUSE_CYCLES < 1) || (REFUSE_CYCLES > REFUSE_PERIOD - 1)) begin : g_bad_cycles
    $error("dmem_param: REFUSE_CYCLES must be in 1..REFUSE_PERIOD-1");
  end

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  logic [PH_W-1:0]    phase_q, phase_d;
  logic               valid_q, valid_d;
  logic               refused_q, refused_d;
  logic [D_WIDTH-1:0] rdata_q, rdata_d;
  logic               in_window;
  logic               accept;

  always_comb begin
    // Power-of-two period lets the counter wrap naturally.
    phase_d   = phase_q + PH_W'(1);
    in_window = (phase_q >= WIN_START);
    accept    = req_i && !in_window;
    valid_d   = accept && !we_i;
    refused_d = req_i && in_window;
    rdata_d   = rdata_q;
    if (valid_d) begin
      rdata_d = mem[addr_i];
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phase_q   <= '0;
      valid_q   <= 1'b0;
      refused_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      refused_q <= refused_d;
    end
  end

  // Storage and read data carry no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (reset_n_i && accept && we_i) begin
      mem[addr_i] <= din_i;
    end
  end

  assign valid_o   = valid_q;
  assign refused_o = refused_q;
  assign dout_o    = valid_q ? rdata_q : '1;

`ifdef DMEM_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr_i) begin
      cnt_d = '0;
    end else if (refused_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign refused_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_dmem_param.sv
// Directed self-checking bench for dmem_param: default schedule plus a
// REFUSE_PERIOD=4 / REFUSE_CYCLES=2 instance sharing the same stimulus.
module tb_dmem_param;

  localparam logic [33:0] ONES   = '1;
  localparam logic [33:0] PAT_A  = 34'h2AAAA5555;
  localparam logic [33:0] PAT_B  = 34'h123456789;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [12:0] addr;
  logic [33:0] din;
  logic [33:0] dout, dout4;
  logic        valid, valid4, refused, refused4;
`ifdef DMEM_STATS_EN
  logic        stats_clr;
  logic [15:0] cnt, cnt4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_param dut (
    .clk(clk), .reset_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .din_i(din), .dout_o(dout), .valid_o(valid), .refused_o(refused)
`ifdef DMEM_STATS_EN
    , .stats_clr_i(stats_clr), .refused_count_o(cnt)
`endif
  );

  dmem_param #(.A_WIDTH(4), .REFUSE_PERIOD(4), .REFUSE_CYCLES(2)) dut4 (
    .clk(clk), .reset_n_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr[3:0]),
    .din_i(din), .dout_o(dout4), .valid_o(valid4), .refused_o(refused4)
`ifdef DMEM_STATS_EN
    , .stats_clr_i(stats_clr), .refused_count_o(cnt4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the phase-0 cycle just after reset release.
  task automatic do_reset();
    req = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    #2;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", valid); end
    n_tests++; if (refused !== 1'b0) begin n_fail++; $display("FAIL rst_refused got %b want 0", refused); end
    n_tests++; if (dout !== ONES) begin n_fail++; $display("FAIL rst_dout got %h want %h", dout, ONES); end
    n_tests++; if (dout4 !== ONES) begin n_fail++; $display("FAIL rst_dout4 got %h want %h", dout4, ONES); end
`ifdef DMEM_STATS_EN
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", cnt); end
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_tests++; if (valid !== 1'b0 || refused !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_idle got v=%b r=%b want 0 0", valid, refused);
    end
  endtask

  task automatic test_write_read();
    do_reset();
    req = 1'b1; we = 1'b1; addr = 13'h005; din = PAT_A;
    tick();
    n_tests++; if (valid !== 1'b0 || refused !== 1'b0) begin
      n_fail++; $display("FAIL wr_resp got v=%b r=%b want 0 0", valid, refused);
    end
    we = 1'b0; addr = 13'h005;
    tick();
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid got %b want 1", valid); end
    n_tests++; if (dout !== PAT_A) begin n_fail++; $display("FAIL rd_dout got %h want %h", dout, PAT_A); end
    req = 1'b0;
    tick();
    n_tests++; if (valid !== 1'b0 || refused !== 1'b0 || dout !== ONES) begin
      n_fail++; $display("FAIL idle_after_rd got v=%b r=%b d=%h want 0 0 %h", valid, refused, dout, ONES);
    end
  endtask

  task automatic test_refusal();
    do_reset();
    req = 1'b1; we = 1'b1; addr = 13'h003; din = PAT_B;
    tick();
    req = 1'b0;
    repeat (6) tick();
    req = 1'b1; we = 1'b1; addr = 13'h003; din = 34'h1;
    tick();
    n_tests++; if (refused !== 1'b1) begin n_fail++; $display("FAIL ref_flag got %b want 1", refused); end
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ref_valid got %b want 0", valid); end
    n_tests++; if (dout !== ONES) begin n_fail++; $display("FAIL ref_dout got %h want %h", dout, ONES); end
    we = 1'b0;
    tick();
    n_tests++; if (valid !== 1'b1 || refused !== 1'b0) begin
      n_fail++; $display("FAIL ref_rd_flags got v=%b r=%b want 1 0", valid, refused);
    end
    n_tests++; if (dout !== PAT_B) begin n_fail++; $display("FAIL ref_rd_dout got %h want %h", dout, PAT_B); end
    req = 1'b0;
    tick();
  endtask

  task automatic test_read_stream();
    int pulses = 0;
    logic exp_ref, exp_ref4;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      req = 1'b1; we = 1'b0; addr = 13'h005;
      tick();
      exp_ref  = ((i % 8) == 7);
      exp_ref4 = ((i % 4) >= 2);
      if (valid === 1'b1) pulses++;
      n_tests++; if (refused !== exp_ref || valid !== !exp_ref || dout !== (exp_ref ? ONES : PAT_A)) begin
        n_fail++; $display("FAIL stream[%0d] got v=%b r=%b d=%h want v=%b r=%b", i, valid, refused, dout, !exp_ref, exp_ref);
      end
      n_tests++; if (refused4 !== exp_ref4 || valid4 !== !exp_ref4 || dout4 !== (exp_ref4 ? ONES : PAT_A)) begin
        n_fail++; $display("FAIL stream4[%0d] got v=%b r=%b d=%h want v=%b r=%b", i, valid4, refused4, dout4, !exp_ref4, exp_ref4);
      end
    end
    req = 1'b0;
    n_tests++; if (pulses != 14) begin n_fail++; $display("FAIL stream_pulses got %0d want 14", pulses); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    req = 1'b1; we = 1'b0; addr = 13'h005;
    tick();
    n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (valid !== 1'b0 || dout !== ONES) begin
      n_fail++; $display("FAIL mid_drop got v=%b d=%h want 0 %h", valid, dout, ONES);
    end
    // A write attempted while reset is held must not land.
    req = 1'b1; we = 1'b1; addr = 13'h005; din = 34'h0;
    tick();
    n_tests++; if (valid !== 1'b0 || refused !== 1'b0) begin
      n_fail++; $display("FAIL mid_held got v=%b r=%b want 0 0", valid, refused);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; we = 1'b0; addr = 13'h005;
      tick();
      n_tests++; if (refused !== (i == 7) || valid !== (i != 7)) begin
        n_fail++; $display("FAIL mid_phase[%0d] got v=%b r=%b want r=%b", i, valid, refused, (i == 7));
      end
      if (i == 0) begin
        n_tests++; if (dout !== PAT_A) begin n_fail++; $display("FAIL mid_wr_blocked got %h want %h", dout, PAT_A); end
      end
    end
    req = 1'b0;
    tick();
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    stats_clr = 1'b0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      req = 1'b1; we = 1'b0; addr = 13'h005;
      tick();
    end
    n_tests++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL stats_cnt got %0d want 3", cnt); end
    for (int i = 24; i < 32; i++) begin
      stats_clr = (i == 31);
      tick();
    end
    stats_clr = 1'b0; req = 1'b0;
    n_tests++; if (refused !== 1'b1) begin n_fail++; $display("FAIL stats_clr_ref got %b want 1", refused); end
    n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL stats_clr_cnt got %0d want 0", cnt); end
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b1; req = 1'b0; we = 1'b0; addr = '0; din = '0;
`ifdef DMEM_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    test_reset();
    test_write_read();
    test_refusal();
    test_read_stream();
    test_reset_mid_read();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
